// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: it latches the operands and opcode, waits a fixed
// settle time or for the divider to finish, and returns the result on a response channel.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int DIV_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op_sel,
    output logic        alu_reset,
    input  logic [31:0] alu_zhigh,
    input  logic [31:0] alu_zlo,
    input  logic        alu_calc_finished,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        busy,
    output logic [2:0]  state_dbg_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready and valid are decoded from registered state only, and a response holds its
    // payload stable until it is taken.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b01111;

    // One counter serves both the settle wait and the divide timeout.
    localparam int CNT_MAX = (SETTLE_CYCLES > DIV_TIMEOUT) ? SETTLE_CYCLES : DIV_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      y_q, y_d, b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             err_q, err_d;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b01111, 5'b10000, 5'b10001, 5'b10010: is_legal = 1'b1;
            default:                                 is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!is_legal(req_op)) begin
                        // Illegal ops leave the ALU inputs untouched.
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        y_d     = req_a;
                        b_d     = req_b;
                        op_d    = req_op;
                        cnt_d   = '0;
                        state_d = (req_op == OP_DIV) ? S_DIV_START : S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    hi_d    = alu_zhigh;
                    lo_d    = alu_zlo;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_DIV_START: begin
                cnt_d   = '0;
                state_d = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (alu_calc_finished) begin
                    hi_d    = alu_zhigh;
                    lo_d    = alu_zlo;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE) && !reset;
        rsp_valid   = (state_q == S_RESP);
        busy        = (state_q != S_IDLE);
        alu_reset   = reset || (state_q == S_DIV_START);
        alu_y       = y_q;
        alu_b       = b_q;
        alu_op_sel  = op_q;
        rsp_hi      = hi_q;
        rsp_lo      = lo_q;
        rsp_err     = err_q;
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays both the control unit and the ALU,
// with hand-computed results and latencies.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_y, alu_b;
    logic [4:0]  alu_op_sel;
    logic        alu_reset;
    logic [31:0] alu_zhigh, alu_zlo;
    logic        alu_calc_finished;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_hi, rsp_lo;
    logic        rsp_err, busy;
    logic [2:0]  state_dbg_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int div_rst_cycles = 0;
    int lat;
    logic seen_valid;

    alu_sequencer #(.SETTLE_CYCLES(1), .DIV_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_y(alu_y), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_reset(alu_reset),
        .alu_zhigh(alu_zhigh), .alu_zlo(alu_zlo), .alu_calc_finished(alu_calc_finished),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
        .busy(busy), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    // Divider-restart pulses outside system reset, sampled on the falling edge.
    always @(negedge clk) if (alu_reset && !reset) div_rst_cycles++;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(input int max_cycles, output int cycles);
        cycles = 1;
        while (!rsp_valid && cycles <= max_cycles) begin
            tick();
            if (!rsp_valid) cycles++;
        end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
            cycles = -1;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("post_consume_ready", 64'(req_ready), 64'd1);
        check_eq("post_consume_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_op = 5'd0; req_a = '0; req_b = '0;
        alu_zhigh = '0; alu_zlo = '0; alu_calc_finished = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        check_eq("rst_ready_low", 64'(req_ready), 64'd0);
        check_eq("rst_alu_reset", 64'(alu_reset), 64'd1);
        reset = 1'b0;
        tick();
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_op", 64'(alu_op_sel), 64'h03);
        check_eq("rst_y_b", {alu_y, alu_b}, 64'd0);
        check_eq("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);

        // ADD 5+7
        alu_zhigh = 32'd0; alu_zlo = 32'd12;
        send(5'b00011, 32'd5, 32'd7);
        check_eq("add_busy", 64'(busy), 64'd1);
        check_eq("add_y", 64'(alu_y), 64'd5);
        check_eq("add_b", 64'(alu_b), 64'd7);
        wait_rsp(10, lat);
        check_eq("add_latency", 64'(lat), 64'd1);
        check_eq("add_rsp", {rsp_hi, rsp_lo}, {32'd0, 32'd12});
        check_eq("add_err", 64'(rsp_err), 64'd0);
        check_eq("add_op_held", 64'(alu_op_sel), 64'h03);
        consume();

        // DIV 100/7, finished 33 cycles after alu_reset drops
        div_rst_cycles = 0;
        alu_zhigh = 32'hDEAD; alu_zlo = 32'hBEEF;
        send(5'b01111, 32'd100, 32'd7);
        check_eq("div_alu_reset_hi", 64'(alu_reset), 64'd1);
        tick();
        check_eq("div_alu_reset_lo", 64'(alu_reset), 64'd0);
        for (int i = 0; i < 32; i++) tick();
        check_eq("div_not_yet", 64'(rsp_valid), 64'd0);
        alu_calc_finished = 1'b1; alu_zhigh = 32'd2; alu_zlo = 32'd14;
        tick();
        alu_calc_finished = 1'b0;
        check_eq("div_valid", 64'(rsp_valid), 64'd1);
        check_eq("div_rsp", {rsp_hi, rsp_lo}, {32'd2, 32'd14});
        check_eq("div_err", 64'(rsp_err), 64'd0);
        check_eq("div_rst_pulse", 64'(div_rst_cycles), 64'd1);
        consume();

        // DIV timeout
        alu_zhigh = 32'hDEAD; alu_zlo = 32'hBEEF;
        send(5'b01111, 32'd100, 32'd7);
        wait_rsp(100, lat);
        check_eq("tmo_latency", 64'(lat), 64'd65);
        check_eq("tmo_err", 64'(rsp_err), 64'd1);
        check_eq("tmo_rsp", {rsp_hi, rsp_lo}, 64'd0);
        consume();

        // Illegal opcode leaves ALU inputs from the last legal op
        send(5'b00000, 32'd1, 32'd2);
        wait_rsp(10, lat);
        check_eq("ill_latency", 64'(lat), 64'd1);
        check_eq("ill_err", 64'(rsp_err), 64'd1);
        check_eq("ill_rsp", {rsp_hi, rsp_lo}, 64'd0);
        check_eq("ill_y_b", {alu_y, alu_b}, {32'd100, 32'd7});
        check_eq("ill_op", 64'(alu_op_sel), 64'h0F);
        consume();

        // MUL with back-pressure and a waiting request
        alu_zhigh = 32'd1; alu_zlo = 32'd0;
        send(5'b10000, 32'h10000, 32'h10000);
        wait_rsp(10, lat);
        check_eq("mul_latency", 64'(lat), 64'd1);
        alu_zhigh = 32'd0; alu_zlo = 32'd7;
        req_valid = 1'b1; req_op = 5'b00011; req_a = 32'd3; req_b = 32'd4;
        for (int i = 0; i < 10; i++) begin
            check_eq("mul_hold_rsp", {rsp_hi, rsp_lo}, 64'h00000001_00000000);
            check_eq("mul_hold_ready", 64'(req_ready), 64'd0);
            check_eq("mul_hold_y", 64'(alu_y), 64'h10000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("mul_done_ready", 64'(req_ready), 64'd1);
        check_eq("mul_done_busy", 64'(busy), 64'd0);
        tick();
        req_valid = 1'b0;
        check_eq("next_accept_busy", 64'(busy), 64'd1);
        check_eq("next_accept_y", 64'(alu_y), 64'd3);
        wait_rsp(10, lat);
        check_eq("next_rsp_lo", 64'(rsp_lo), 64'd7);
        consume();

        // Reset during DIV_WAIT discards the op
        send(5'b01111, 32'd9, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        check_eq("mid_rst_alu_reset", 64'(alu_reset), 64'd1);
        check_eq("mid_rst_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(req_ready), 64'd1);
        check_eq("post_rst_y", 64'(alu_y), 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (rsp_valid) seen_valid = 1'b1;
        end
        check_eq("post_rst_no_rsp", 64'(seen_valid), 64'd0);
        alu_zhigh = 32'd0; alu_zlo = 32'd7;
        send(5'b00011, 32'd3, 32'd4);
        wait_rsp(10, lat);
        check_eq("post_rst_add", {rsp_hi, rsp_lo, 31'd0, rsp_err} >> 32, {32'd0, 32'd7});
        check_eq("post_rst_add_err", 64'(rsp_err), 64'd0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator side of the ALU operation interface. It accepts one operation request per valid/ready handshake and drives the ALU's operand, opcode and divider-restart inputs. It waits either a fixed settle time (single-cycle ops) or for `calc_finished` (DIV), then captures the ALU's high/low result words and returns them on a valid/ready response channel. It sits between the control unit and the ALU, replacing ad-hoc op_sel/Z-register strobing.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the operands are held on the ALU before a non-DIV result is captured; must be at least 1.
- `DIV_TIMEOUT`, default 64: maximum number of DIV_WAIT cycles before a divide is aborted with an error.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request; high only in IDLE.
- `req_op`  in  5  ALU opcode.
- `req_a`  in  32  first operand; driven to the ALU Y input.
- `req_b`  in  32  second operand; driven to the ALU B input.
- `alu_y`  out  32  latched first operand.
- `alu_b`  out  32  latched second operand.
- `alu_op_sel`  out  5  latched opcode.
- `alu_reset`  out  1  divider restart.
- `alu_zhigh`  in  32  ALU high result word.
- `alu_zlo`  in  32  ALU low result word.
- `alu_calc_finished`  in  1  divider done.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_hi`  out  32  captured high word (remainder for DIV).
- `rsp_lo`  out  32  captured low word (quotient for DIV).
- `rsp_err`  out  1  illegal opcode or divide timeout.
- `busy`  out  1  state other than IDLE.

## Operation
- Legal opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110
  - ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011
  - DIV 01111, MUL 10000, NEG 10001, NOT 10010
  - Every other opcode is illegal.
- States: IDLE, SETTLE, DIV_START, DIV_WAIT, RESP.
- IDLE: `req_ready`=1. A request is accepted when `req_valid && req_ready`. On acceptance, `req_a`/`req_b`/`req_op` are latched into `alu_y`/`alu_b`/`alu_op_sel`. The next state depends on the opcode:
  - Illegal opcode: go to RESP with `rsp_err`=1 and `rsp_hi`=`rsp_lo`=0. The ALU outputs keep their previous values.
  - DIV: go to DIV_START.
  - Any other legal opcode: go to SETTLE, clearing the settle counter.
- SETTLE: the counter increments each cycle. In the cycle where the counter equals SETTLE_CYCLES-1, `alu_zhigh`/`alu_zlo` are captured into `rsp_hi`/`rsp_lo` with `rsp_err`=0, and the state moves to RESP.
- DIV_START: lasts exactly one cycle with `alu_reset`=1. Moves to DIV_WAIT with the timeout counter cleared.
- DIV_WAIT: `alu_calc_finished` is sampled every cycle.
  - If it is 1: capture the result, `rsp_err`=0, go to RESP.
  - Else, if the counter equals DIV_TIMEOUT-1: `rsp_err`=1, `rsp_hi`=`rsp_lo`=0, go to RESP.
  - Else: increment the counter.
  - If finished and timeout coincide in the same cycle, finished wins.
- RESP: `rsp_valid`=1. `rsp_hi`/`rsp_lo`/`rsp_err` are held stable until `rsp_valid && rsp_ready`, then the state returns to IDLE.
- `alu_y`, `alu_b` and `alu_op_sel` change only on request acceptance, so they are stable from acceptance until the response is consumed.
- `alu_reset` = `reset` OR (state == DIV_START). The divider is therefore also cleared during a system reset.
- Reset (any state, including mid-DIV or mid-RESP): state goes to IDLE and the pending operation is discarded with no response. Values after reset:
  - `rsp_valid`=0, `rsp_err`=0, `rsp_hi`=`rsp_lo`=0
  - `alu_y`=`alu_b`=0, `alu_op_sel`=00011 (ADD)
  - `busy`=0, counters 0
  - `req_ready`=1 in the first cycle after reset deasserts; `req_ready`=0 while `reset` is high.

## Timing
- Non-DIV op accepted at edge E: result captured at edge E+SETTLE_CYCLES; `rsp_valid` is high from edge E+SETTLE_CYCLES onward (the cycle after capture).
- Illegal op accepted at edge E: `rsp_valid` high from edge E+1.
- DIV accepted at edge E: `alu_reset` is high for the single cycle E..E+1. DIV_WAIT begins after edge E+1. If `alu_calc_finished` is sampled high at edge F, `rsp_valid` is high after edge F.
- DIV timeout: `rsp_valid` is high after edge E+1+DIV_TIMEOUT.
- Response consumed at edge R: `req_ready`=1 after R. The earliest next acceptance is edge R+1; there is no request/response overlap.
- `req_ready`, `rsp_valid` and `busy` are decoded from registered state only, with no combinational path from `req_valid` or `rsp_ready`.

## Test plan
- ADD, req_a=5, req_b=7, ALU model returns zlo=12, zhigh=0, SETTLE_CYCLES=1, accepted at E -> `rsp_valid` after E+1, `rsp_hi`=0, `rsp_lo`=12, `rsp_err`=0; `alu_op_sel`=00011 held throughout.
- DIV, req_a=100, req_b=7, model asserts finished 33 cycles after `alu_reset` drops with zhigh=2, zlo=14 -> `alu_reset` high exactly 1 cycle; response {2,14}, `rsp_err`=0.
- DIV with `alu_calc_finished` stuck at 0, DIV_TIMEOUT=64 -> `rsp_valid` after E+65, `rsp_err`=1, `rsp_hi`=`rsp_lo`=0.
- Illegal opcode 00000 -> `rsp_valid` one cycle after acceptance, `rsp_err`=1, `alu_y`/`alu_b`/`alu_op_sel` unchanged.
- MUL result 0x00000001_00000000, `rsp_ready` low for 10 cycles while `req_valid` stays high -> response fields stable, `req_ready`=0, no second acceptance; after `rsp_ready`, the next request is accepted one cycle later.
- `reset` pulsed during DIV_WAIT -> `rsp_valid` never asserts for that op, `alu_reset`=1 during reset, `req_ready`=1 after reset; a following ADD 3+4 returns `rsp_lo`=7.
